vram_arbiter: RTL

- Shares one single-port synchronous text RAM (4K, byte-wide, at $B8000-$B8FFF) between the CPU and the text-mode GPU.
- GPU fetches have priority and never stall; the GPU may see a bounded 1-cycle delay.
- CPU accesses wait for free slots. A starvation counter forces a CPU grant after MAX_WAIT lost cycles.
- Sits between cpu/gpu and the text RAM in the de0 top level, replacing the dual-port arrangement.

---
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: one single-port text RAM shared by GPU fetches (priority) and CPU accesses.
// Optional macro VRAM_ARB_STATS_EN adds stat_cpu_wait, a saturating count of CPU-lost edges.

module vram_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          gpu_req,
  input  logic [AW-1:0] gpu_address,
  output logic [DW-1:0] gpu_data,
  output logic          gpu_valid,
  output logic          gpu_overrun,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_d,
  output logic          ram_w,
  input  logic [DW-1:0] ram_q
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu_wait
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  function automatic logic [3:0] wait_inc(input logic [3:0] v);
    return (v >= WAIT_MAX) ? v : v + 4'd1;
  endfunction

  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [3:0]    wait_q, wait_d;
  logic          gpu_vld_p0_q, gpu_vld_p1_q;
  logic          cpu_rd_p0_q, cpu_rd_p1_q, cpu_wr_p0_q;

  logic          cpu_busy, cpu_c, cpu_gnt, gpu_gnt, serve_pend, overrun_set;
  logic [AW-1:0] gpu_gnt_addr;

  // A CPU request held through its own ready cycle must not be issued twice.
  assign cpu_busy = cpu_rd_p0_q | cpu_rd_p1_q | cpu_wr_p0_q;
  assign cpu_c    = cpu_req & ~cpu_busy & ~cpu_ready;

  always_comb begin
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    gpu_gnt      = 1'b0;
    gpu_gnt_addr = gpu_address;
    cpu_gnt      = 1'b0;
    serve_pend   = 1'b0;
    if (pend_q) begin
      serve_pend   = 1'b1;
      gpu_gnt      = 1'b1;
      gpu_gnt_addr = pend_addr_q;
      pend_d       = gpu_req;
      if (gpu_req) pend_addr_d = gpu_address;
    end else if (cpu_c && (wait_q == WAIT_MAX)) begin
      cpu_gnt = 1'b1;
      if (gpu_req) begin
        pend_d      = 1'b1;
        pend_addr_d = gpu_address;
      end
    end else if (gpu_req) begin
      gpu_gnt = 1'b1;
    end else if (cpu_c) begin
      cpu_gnt = 1'b1;
    end
  end

  assign overrun_set = gpu_req & pend_q & ~serve_pend;

  always_comb begin
    if (!cpu_req || cpu_gnt) wait_d = 4'd0;
    else if (cpu_c)          wait_d = wait_inc(wait_q);
    else                     wait_d = wait_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      wait_q       <= 4'd0;
      ram_address  <= '0;
      ram_d        <= '0;
      ram_w        <= 1'b0;
      gpu_vld_p0_q <= 1'b0;
      gpu_vld_p1_q <= 1'b0;
      cpu_rd_p0_q  <= 1'b0;
      cpu_rd_p1_q  <= 1'b0;
      cpu_wr_p0_q  <= 1'b0;
      gpu_valid    <= 1'b0;
      gpu_data     <= '0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      gpu_overrun  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      wait_q      <= wait_d;
      // Stage 0: grant registered onto the RAM port
      if (cpu_gnt)      ram_address <= cpu_address;
      else if (gpu_gnt) ram_address <= gpu_gnt_addr;
      ram_w <= cpu_gnt & cpu_we;
      if (cpu_gnt && cpu_we) ram_d <= cpu_wdata;
      gpu_vld_p0_q <= gpu_gnt;
      cpu_rd_p0_q  <= cpu_gnt & ~cpu_we;
      cpu_wr_p0_q  <= cpu_gnt & cpu_we;
      // Stage 1: RAM samples the address
      gpu_vld_p1_q <= gpu_vld_p0_q;
      cpu_rd_p1_q  <= cpu_rd_p0_q;
      // Stage 2: capture ram_q and pulse completion
      gpu_valid <= gpu_vld_p1_q;
      if (gpu_vld_p1_q) gpu_data <= ram_q;
      cpu_ready <= cpu_wr_p0_q | cpu_rd_p1_q;
      if (cpu_rd_p1_q) cpu_rdata <= ram_q;
      if (overrun_set) gpu_overrun <= 1'b1;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  function automatic logic [15:0] stat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic cpu_lost;
  assign cpu_lost = cpu_c & ~cpu_gnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      stat_cpu_wait <= 16'd0;
    else if (cpu_lost) stat_cpu_wait <= stat_inc(stat_cpu_wait);
  end
`endif

endmodule
